noc_router_node: RTL and testbench

- Parametrised successor to the fixed 3-port router node. One configurable node replaces the corner, edge and interior variants: up to 5 ports (local, N, E, S, W), selected by a port-enable mask.
- Per-input flit FIFO of configurable depth, XY route computation, per-output round-robin arbitration.
- Wormhole locking: a multi-flit packet holds its output until the last flit.
- Packets routed to a disabled port are drained internally and counted.

---
 rtl/noc_router_node_pkg.sv | 54 +++++
 rtl/noc_router_node_if.sv | 32 +++
 rtl/noc_router_node_fifo.sv | 55 +++++
 rtl/noc_router_node.sv | 217 +++++++++++++++++++++
 tb/tb_noc_router_node.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_router_node_pkg.sv
// Shared types and helpers for the configurable mesh router node.
// Port numbering and header field layout are used by the router, the FIFO wrapper and the bench.
package noc_router_node_pkg;

   localparam int NUM_PORTS  = 5;
   localparam int PORT_IDX_W = 3;

   localparam int P_LOCAL = 0;
   localparam int P_NORTH = 1;
   localparam int P_EAST  = 2;
   localparam int P_SOUTH = 3;
   localparam int P_WEST  = 4;

   localparam int HDR_Y_LSB   = 0;
   localparam int HDR_Y_W     = 4;
   localparam int HDR_X_LSB   = 4;
   localparam int HDR_X_W     = 4;
   localparam int HDR_LEN_LSB = 8;
   localparam int HDR_LEN_W   = 8;

   typedef logic [PORT_IDX_W-1:0] port_idx_t;
   typedef logic [HDR_LEN_W-1:0]  len_t;

   typedef enum logic [2:0] {
      ROUTE_LOCAL = 3'd0,
      ROUTE_NORTH = 3'd1,
      ROUTE_EAST  = 3'd2,
      ROUTE_SOUTH = 3'd3,
      ROUTE_WEST  = 3'd4
   } route_t;

   typedef enum logic {
      IN_FWD,
      IN_DROP
   } in_state_t;

   typedef enum logic {
      OUT_IDLE,
      OUT_LOCKED
   } out_state_t;

   // Dimension-order routing: resolve X first, then Y; Y grows northward.
   function automatic route_t xy_route(input logic [3:0] dest_x,
                                       input logic [3:0] dest_y,
                                       input logic [3:0] node_x,
                                       input logic [3:0] node_y);
      if (dest_x > node_x)      return ROUTE_EAST;
      else if (dest_x < node_x) return ROUTE_WEST;
      else if (dest_y > node_y) return ROUTE_NORTH;
      else if (dest_y < node_y) return ROUTE_SOUTH;
      else                      return ROUTE_LOCAL;
   endfunction

endpackage

// File: rtl/noc_router_node_if.sv
// Flit handshake bundle for all five router ports, flattened per direction.
// The router takes the slave view; whatever sits around it takes the master view.
interface noc_router_node_if #(
   parameter int DATA_W = 16
);

   logic [noc_router_node_pkg::NUM_PORTS*DATA_W-1:0] in_data;
   logic [noc_router_node_pkg::NUM_PORTS-1:0]        in_valid;
   logic [noc_router_node_pkg::NUM_PORTS-1:0]        in_ready;
   logic [noc_router_node_pkg::NUM_PORTS*DATA_W-1:0] out_data;
   logic [noc_router_node_pkg::NUM_PORTS-1:0]        out_valid;
   logic [noc_router_node_pkg::NUM_PORTS-1:0]        out_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready
   );

endinterface

// File: rtl/noc_router_node_fifo.sv
// Per-input flit FIFO with a combinational head so the crossbar can forward the
// flit in the cycle after it was written. A push while full is ignored.
module flit_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   logic [DATA_W-1:0] mem_q [DEPTH];
   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   logic              do_push;
   logic              do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign valid_o = (wr_ptr_q != rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & valid_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/noc_router_node.sv
// Configurable 5-port mesh router node: per-input FIFOs, XY routing, per-output
// round-robin arbitration with wormhole locking, and internal draining of packets to absent ports.
module noc_router_node
   import noc_router_node_pkg::*;
#(
   parameter int                   NODE_X     = 0,
   parameter int                   NODE_Y     = 0,
   parameter logic [NUM_PORTS-1:0] PORT_EN    = 5'b11111,
   parameter int                   DATA_W     = 16,
   parameter int                   FIFO_DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   noc_router_node_if.slave        bus_if,
   output logic [7:0]              drop_count_o
);

   localparam logic [NUM_PORTS-1:0] PEN = PORT_EN;

   logic [DATA_W-1:0]    head       [NUM_PORTS];
   logic [NUM_PORTS-1:0] fifo_valid;
   logic [NUM_PORTS-1:0] fifo_full;
   logic [NUM_PORTS-1:0] fifo_pop;
   route_t               route      [NUM_PORTS];
   len_t                 hdr_len    [NUM_PORTS];

   out_state_t           out_state_q [NUM_PORTS], out_state_d [NUM_PORTS];
   port_idx_t            owner_q     [NUM_PORTS], owner_d     [NUM_PORTS];
   len_t                 rem_q       [NUM_PORTS], rem_d       [NUM_PORTS];
   port_idx_t            rr_q        [NUM_PORTS], rr_d        [NUM_PORTS];
   in_state_t            in_state_q  [NUM_PORTS], in_state_d  [NUM_PORTS];
   len_t                 drop_rem_q  [NUM_PORTS], drop_rem_d  [NUM_PORTS];
   logic [7:0]           drop_cnt_q, drop_cnt_d;

   logic [NUM_PORTS-1:0] owned;
   logic [NUM_PORTS-1:0] req        [NUM_PORTS];
   port_idx_t            win        [NUM_PORTS];
   logic [NUM_PORTS-1:0] out_valid;
   logic [DATA_W-1:0]    out_data   [NUM_PORTS];
   logic [NUM_PORTS-1:0] xfer;
   logic [NUM_PORTS-1:0] drop_hdr;

   // Next enabled port after w, wrapping; w itself if it is the only one enabled.
   function automatic port_idx_t rr_after(input port_idx_t w);
      port_idx_t cand;
      rr_after = w;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = port_idx_t'((int'(w) + k) % NUM_PORTS);
         if (PEN[cand]) rr_after = cand;
      end
   endfunction

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      if (PORT_EN[gi]) begin : g_en
         flit_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
         ) u_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .push_i      (bus_if.in_valid[gi] & bus_if.in_ready[gi]),
            .push_data_i (bus_if.in_data[gi*DATA_W +: DATA_W]),
            .pop_i       (fifo_pop[gi]),
            .full_o      (fifo_full[gi]),
            .valid_o     (fifo_valid[gi]),
            .head_o      (head[gi])
         );
      end else begin : g_dis
         assign fifo_full[gi]  = 1'b1;
         assign fifo_valid[gi] = 1'b0;
         assign head[gi]       = '0;
      end

      assign route[gi]   = xy_route(head[gi][HDR_X_LSB +: HDR_X_W],
                                    head[gi][HDR_Y_LSB +: HDR_Y_W],
                                    4'(NODE_X), 4'(NODE_Y));
      assign hdr_len[gi] = head[gi][HDR_LEN_LSB +: HDR_LEN_W];

      assign bus_if.in_ready[gi]                    = PEN[gi] & ~fifo_full[gi] & rst_ni;
      assign bus_if.out_valid[gi]                   = out_valid[gi];
      assign bus_if.out_data[gi*DATA_W +: DATA_W]   = out_data[gi];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            out_state_q[i] <= OUT_IDLE;
            owner_q[i]     <= '0;
            rem_q[i]       <= '0;
            rr_q[i]        <= '0;
            in_state_q[i]  <= IN_FWD;
            drop_rem_q[i]  <= '0;
         end
         drop_cnt_q <= '0;
      end else begin
         out_state_q <= out_state_d;
         owner_q     <= owner_d;
         rem_q       <= rem_d;
         rr_q        <= rr_d;
         in_state_q  <= in_state_d;
         drop_rem_q  <= drop_rem_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Crossbar, arbitration and pop generation.
   always_comb begin
      logic      found;
      port_idx_t cand;
      found    = 1'b0;
      cand     = '0;
      owned    = '0;
      out_valid = '0;
      xfer     = '0;
      fifo_pop = '0;
      drop_hdr = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         out_data[o] = '0;
         win[o]      = '0;
         req[o]      = '0;
      end

      for (int o = 0; o < NUM_PORTS; o++) begin
         if (PEN[o] && out_state_q[o] == OUT_LOCKED) owned[owner_q[o]] = 1'b1;
      end

      // A non-busy FWD input always has a header at its head.
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            req[o][p] = PEN[o] && PEN[p] && fifo_valid[p] &&
                        (in_state_q[p] == IN_FWD) && !owned[p] &&
                        (int'(route[p]) == o);
         end
      end

      for (int o = 0; o < NUM_PORTS; o++) begin
         if (PEN[o]) begin
            if (out_state_q[o] == OUT_IDLE) begin
               found = 1'b0;
               for (int k = 0; k < NUM_PORTS; k++) begin
                  cand = port_idx_t'((int'(rr_q[o]) + k) % NUM_PORTS);
                  if (!found && req[o][cand]) begin
                     win[o] = cand;
                     found  = 1'b1;
                  end
               end
               out_valid[o] = found;
            end else begin
               win[o]       = owner_q[o];
               out_valid[o] = fifo_valid[owner_q[o]];
            end
            if (out_valid[o]) out_data[o] = head[win[o]];
            xfer[o] = out_valid[o] & bus_if.out_ready[o];
            if (xfer[o]) fifo_pop[win[o]] = 1'b1;
         end
      end

      for (int p = 0; p < NUM_PORTS; p++) begin
         if (PEN[p]) begin
            if (in_state_q[p] == IN_FWD) begin
               if (fifo_valid[p] && !owned[p] && !PEN[route[p]]) begin
                  drop_hdr[p] = 1'b1;
                  fifo_pop[p] = 1'b1;
               end
            end else if (fifo_valid[p]) begin
               fifo_pop[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      int n_drop;
      out_state_d = out_state_q;
      owner_d     = owner_q;
      rem_d       = rem_q;
      rr_d        = rr_q;
      in_state_d  = in_state_q;
      drop_rem_d  = drop_rem_q;
      n_drop      = 0;

      for (int o = 0; o < NUM_PORTS; o++) begin
         if (xfer[o]) begin
            if (out_state_q[o] == OUT_IDLE) begin
               rr_d[o] = rr_after(win[o]);
               if (hdr_len[win[o]] != '0) begin
                  out_state_d[o] = OUT_LOCKED;
                  owner_d[o]     = win[o];
                  rem_d[o]       = hdr_len[win[o]];
               end
            end else begin
               rem_d[o] = rem_q[o] - len_t'(1);
               if (rem_q[o] == len_t'(1)) out_state_d[o] = OUT_IDLE;
            end
         end
      end

      for (int p = 0; p < NUM_PORTS; p++) begin
         if (drop_hdr[p]) begin
            n_drop = n_drop + 1;
            if (hdr_len[p] != '0) begin
               in_state_d[p] = IN_DROP;
               drop_rem_d[p] = hdr_len[p];
            end
         end else if (in_state_q[p] == IN_DROP && fifo_pop[p]) begin
            drop_rem_d[p] = drop_rem_q[p] - len_t'(1);
            if (drop_rem_q[p] == len_t'(1)) in_state_d[p] = IN_FWD;
         end
      end

      if (int'(drop_cnt_q) + n_drop > 255) drop_cnt_d = 8'hFF;
      else                                 drop_cnt_d = 8'(int'(drop_cnt_q) + n_drop);
   end

   assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_noc_router_node.sv
// Scoreboard bench: an interior node (1,1, all ports) and a partially populated node (0,1, L/N/E)
// share clock and reset; stimulus queues feed inputs, expected queues are checked by a monitor.
`timescale 1ns/1ps
module tb_noc_router_node;
   import noc_router_node_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   noc_router_node_if #(.DATA_W(16)) ifa ();
   noc_router_node_if #(.DATA_W(16)) ifb ();
   logic [7:0] a_drop;
   logic [7:0] b_drop;

   noc_router_node #(
      .NODE_X(1), .NODE_Y(1), .PORT_EN(5'b11111), .DATA_W(16), .FIFO_DEPTH(4)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus_if(ifa), .drop_count_o(a_drop)
   );

   noc_router_node #(
      .NODE_X(0), .NODE_Y(1), .PORT_EN(5'b00111), .DATA_W(16), .FIFO_DEPTH(4)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus_if(ifb), .drop_count_o(b_drop)
   );

   // Index i = dut*5 + port; dut 0 is ifa, dut 1 is ifb.
   logic [15:0] drv_data  [10];
   logic        drv_valid [10];
   logic        ordy      [10];
   logic        acc       [10];
   logic [15:0] stim      [10][$];
   logic [15:0] expq      [10][$];
   int          checks   = 0;
   int          failures = 0;

   for (genvar gi = 0; gi < 5; gi++) begin : g_drv
      assign ifa.in_data[gi*16 +: 16] = drv_data[gi];
      assign ifa.in_valid[gi]         = drv_valid[gi];
      assign ifa.out_ready[gi]        = ordy[gi];
      assign ifb.in_data[gi*16 +: 16] = drv_data[gi+5];
      assign ifb.in_valid[gi]         = drv_valid[gi+5];
      assign ifb.out_ready[gi]        = ordy[gi+5];
   end

   function automatic logic in_rdy(input int i);
      if (i < 5) return ifa.in_ready[i];
      return ifb.in_ready[i-5];
   endfunction

   function automatic logic ovalid(input int i);
      if (i < 5) return ifa.out_valid[i];
      return ifb.out_valid[i-5];
   endfunction

   function automatic logic [15:0] odata(input int i);
      int p;
      p = i % 5;
      if (i < 5) return ifa.out_data[p*16 +: 16];
      return ifb.out_data[p*16 +: 16];
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Driver: present queue heads, retire a flit after the edge on which it was accepted.
   initial begin
      for (int i = 0; i < 10; i++) begin
         drv_valid[i] = 1'b0;
         drv_data[i]  = '0;
         acc[i]       = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 10; i++) acc[i] = drv_valid[i] && in_rdy(i);
         @(posedge clk);
         #1;
         for (int i = 0; i < 10; i++) begin
            if (acc[i] && stim[i].size() > 0) void'(stim[i].pop_front());
            if (stim[i].size() > 0 && rst_n) begin
               drv_valid[i] = 1'b1;
               drv_data[i]  = stim[i][0];
            end else begin
               drv_valid[i] = 1'b0;
               drv_data[i]  = '0;
            end
         end
      end
   end

   // Monitor: every output transfer must match the head of its expected queue.
   initial begin
      logic [15:0] got;
      logic [15:0] exp;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            if (rst_n && ovalid(i) && ordy[i]) begin
               got = odata(i);
               checks++;
               if (expq[i].size() == 0) begin
                  failures++;
                  $display("FAIL out_unexpected dut%0d port%0d got=%h expected=none", i/5, i%5, got);
               end else begin
                  exp = expq[i].pop_front();
                  if (got !== exp) begin
                     failures++;
                     $display("FAIL out_flit dut%0d port%0d got=%h expected=%h", i/5, i%5, got, exp);
                  end
               end
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n;
      int pending;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         pending = 0;
         for (int i = 0; i < 10; i++) pending += stim[i].size() + expq[i].size();
      end while (pending != 0 && n < budget);
      repeat (3) @(posedge clk);
      checks++;
      if (pending != 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d expected=0 after %0d cycles", name, pending, budget);
      end else begin
         $display("drained %s in %0d cycles", name, n);
      end
   endtask

   task automatic push_pkt(input int i, input logic [15:0] hdr, input int nbody, input logic [15:0] base);
      stim[i].push_back(hdr);
      for (int k = 1; k <= nbody; k++) stim[i].push_back(base + 16'(k));
   endtask

   task automatic expect_pkt(input int i, input logic [15:0] hdr, input int nbody, input logic [15:0] base);
      expq[i].push_back(hdr);
      for (int k = 1; k <= nbody; k++) expq[i].push_back(base + 16'(k));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 10; i++) ordy[i] = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_out_valid", 32'(ifa.out_valid), 32'h0);
      chk("rst_a_out_data_any", 32'(|ifa.out_data), 32'h0);
      chk("rst_a_in_ready", 32'(ifa.in_ready), 32'h0);
      chk("rst_b_in_ready", 32'(ifb.in_ready), 32'h0);
      chk("rst_b_drop", 32'(b_drop), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_a_in_ready", 32'(ifa.in_ready), 32'h1F);
      chk("rel_b_in_ready", 32'(ifb.in_ready), 32'h07);

      // Single-flit header local -> E, one cycle after acceptance.
      @(posedge clk);
      #2;
      stim[P_LOCAL].push_back(16'h0023);
      expq[P_EAST].push_back(16'h0023);
      @(posedge clk);
      @(negedge clk);
      chk("t1_e_valid_before_accept", 32'(ifa.out_valid[P_EAST]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("t1_e_valid_one_cycle_after", 32'(ifa.out_valid[P_EAST]), 32'h1);
      chk("t1_e_data", 32'(ifa.out_data[P_EAST*16 +: 16]), 32'h0023);
      chk("t1_a_drop", 32'(a_drop), 32'h0);
      wait_drain("t1", 50);

      // N and S contend for local in the same cycle; N wins and keeps the lock.
      @(posedge clk);
      #2;
      push_pkt(P_NORTH, 16'h0211, 2, 16'hA000);
      push_pkt(P_SOUTH, 16'h0211, 2, 16'hB000);
      expect_pkt(P_LOCAL, 16'h0211, 2, 16'hA000);
      expect_pkt(P_LOCAL, 16'h0211, 2, 16'hB000);
      wait_drain("t2", 100);

      // Backpressure on E fills the local FIFO.
      @(posedge clk);
      #2;
      ordy[P_EAST] = 1'b0;
      push_pkt(P_LOCAL, 16'h0625, 6, 16'hC000);
      expect_pkt(P_EAST, 16'h0625, 6, 16'hC000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t3_in_ready_full", 32'(ifa.in_ready[P_LOCAL]), 32'h0);
      chk("t3_flits_waiting", 32'(stim[P_LOCAL].size()), 32'd3);
      chk("t3_e_valid_held", 32'(ifa.out_valid[P_EAST]), 32'h1);
      chk("t3_e_head_held", 32'(ifa.out_data[P_EAST*16 +: 16]), 32'h0625);
      @(posedge clk);
      #2;
      ordy[P_EAST] = 1'b1;
      wait_drain("t3", 100);

      // Node B: header to absent S port is drained, then E traffic still flows.
      @(posedge clk);
      #2;
      push_pkt(5 + P_LOCAL, 16'h0300, 3, 16'hD000);
      stim[5 + P_LOCAL].push_back(16'h0011);
      expq[5 + P_EAST].push_back(16'h0011);
      wait_drain("t4", 100);
      chk("t4_b_drop", 32'(b_drop), 32'd1);
      chk("t4_b_sw_in_ready", 32'({ifb.in_ready[P_WEST], ifb.in_ready[P_SOUTH]}), 32'h0);

      // Lock E with a 5-body packet, show W is blocked, then reset mid-packet.
      @(posedge clk);
      #2;
      stim[P_LOCAL].push_back(16'h0525);
      expq[P_EAST].push_back(16'h0525);
      wait_drain("t5_hdr", 50);
      @(posedge clk);
      #2;
      stim[P_WEST].push_back(16'h0023);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t5_lock_blocks_w", 32'(ifa.out_valid[P_EAST]), 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_a_out_valid", 32'(ifa.out_valid), 32'h0);
      chk("t5_rst_a_in_ready", 32'(ifa.in_ready), 32'h0);
      chk("t5_rst_b_drop", 32'(b_drop), 32'h0);
      for (int i = 0; i < 10; i++) begin
         stim[i].delete();
         expq[i].delete();
      end
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      stim[P_WEST].push_back(16'h0023);
      expq[P_EAST].push_back(16'h0023);
      wait_drain("t5_after", 50);

      // Saturation: local and N drop in parallel, then approach and pass 255.
      @(posedge clk);
      #2;
      for (int k = 0; k < 100; k++) begin
         stim[5 + P_LOCAL].push_back(16'h0000);
         stim[5 + P_NORTH].push_back(16'h0000);
      end
      wait_drain("t6a", 400);
      chk("t6_drop_200", 32'(b_drop), 32'd200);
      for (int k = 0; k < 54; k++) stim[5 + P_LOCAL].push_back(16'h0000);
      wait_drain("t6b", 200);
      chk("t6_drop_254", 32'(b_drop), 32'd254);
      for (int k = 0; k < 46; k++) stim[5 + P_LOCAL].push_back(16'h0000);
      wait_drain("t6c", 200);
      chk("t6_drop_sat", 32'(b_drop), 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
